// File: rtl/sample_collector_if.sv
// Bus bundle between the sample collector, the pin channels and the downstream FIFO reader.
// fifo_data widens from 40 to 72 bits when SAMPLE_TIMESTAMP_EN is defined.
interface sample_collector_if;
`ifdef SAMPLE_TIMESTAMP_EN
    localparam int ENTRY_W = 72;
`else
    localparam int ENTRY_W = 40;
`endif

    logic               enable;
    logic [31:0]        current_time;
    logic               output_sample;
    logic [7:0]         channel_select;
    logic [31:0]        sample_data;
    logic               fifo_rd;
    logic [ENTRY_W-1:0] fifo_data;
    logic               fifo_empty;
    logic               fifo_full;
    logic [8:0]         fifo_count;
    logic               overflow;
    logic               clear_overflow;
    logic [15:0]        bad_frame_cnt;

    // master is the collector itself; slave is the channel/reader environment around it.
    modport master (
        input  enable, current_time, sample_data, fifo_rd, clear_overflow,
        output output_sample, channel_select, fifo_data, fifo_empty, fifo_full,
               fifo_count, overflow, bad_frame_cnt
    );

    modport slave (
        output enable, current_time, sample_data, fifo_rd, clear_overflow,
        input  output_sample, channel_select, fifo_data, fifo_empty, fifo_full,
               fifo_count, overflow, bad_frame_cnt
    );
endinterface

// File: rtl/sample_collector.sv
// Scans pin channels round-robin, keeps frames whose counter changed, and queues them in a FWFT FIFO.
// Optional SAMPLE_TIMESTAMP_EN prefixes every entry with current_time captured in the CAPT cycle.
module sample_collector #(
    parameter int NUM_CHANNELS = 8,
    parameter int FIFO_DEPTH   = 16
) (
    input logic                clk,
    input logic                reset,
    sample_collector_if.master bus
);
`ifdef SAMPLE_TIMESTAMP_EN
    localparam int ENTRY_W = 72;
`else
    localparam int ENTRY_W = 40;
`endif
    localparam int          AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int          CW      = (NUM_CHANNELS > 1) ? $clog2(NUM_CHANNELS) : 1;
    localparam logic [7:0]  LAST_CH = 8'(NUM_CHANNELS - 1);
    localparam logic [8:0]  DEPTH   = 9'(FIFO_DEPTH);
    localparam logic [14:0] MARKER  = 15'h55E7;

    typedef enum logic [1:0] {IDLE, REQ, CAPT} state_e;

    state_e             state_q;
    logic [7:0]         ch_q, ch_d;
    logic               output_sample_q;
    logic [7:0]         channel_select_q;
    logic [15:0]        bad_frame_cnt_q;
    logic [15:0]        last_cnt_q [2**CW];
    logic               overflow_q, overflow_d;
    logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]      rd_ptr_q, wr_ptr_q;
    logic [8:0]         count_q, count_d;

    logic               run, in_capt, frame_valid, push_req, push, pop, full, empty;
    logic [ENTRY_W-1:0] entry;

    assign run         = bus.enable && (bus.current_time != 32'd0);
    assign in_capt     = (state_q == CAPT);
    assign frame_valid = (bus.sample_data[15:1] == MARKER);
    assign push_req    = in_capt && frame_valid
                         && (bus.sample_data[31:16] != last_cnt_q[ch_q[CW-1:0]]);
    assign empty       = (count_q == 9'd0);
    assign full        = (count_q == DEPTH);
    assign pop         = bus.fifo_rd && !empty;
    // A full FIFO still accepts the push when the same edge frees a slot.
    assign push        = push_req && (!full || pop) && !reset;
    assign ch_d        = (ch_q == LAST_CH) ? 8'd0 : ch_q + 8'd1;

`ifdef SAMPLE_TIMESTAMP_EN
    assign entry = {bus.current_time, ch_q, bus.sample_data};
`else
    assign entry = {ch_q, bus.sample_data};
`endif

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (reset) begin
            state_q          <= IDLE;
            ch_q             <= 8'd0;
            output_sample_q  <= 1'b0;
            channel_select_q <= 8'd0;
        end else begin
            output_sample_q <= 1'b0;
            unique case (state_q)
                IDLE: if (run) begin
                    state_q          <= REQ;
                    output_sample_q  <= 1'b1;
                    channel_select_q <= ch_q;
                end
                REQ:  state_q <= CAPT;
                CAPT: begin
                    ch_q <= ch_d;
                    if (run) begin
                        state_q          <= REQ;
                        output_sample_q  <= 1'b1;
                        channel_select_q <= ch_d;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bad_frame_cnt_q <= 16'd0;
            for (int i = 0; i < 2**CW; i++) last_cnt_q[i] <= 16'd0;
        end else if (in_capt) begin
            if (!frame_valid) begin
                if (bad_frame_cnt_q != 16'hFFFF) bad_frame_cnt_q <= bad_frame_cnt_q + 16'd1;
            end else begin
                last_cnt_q[ch_q[CW-1:0]] <= bus.sample_data[31:16];
            end
        end
    end

    always_comb begin
        // NOTE: defaults first so every path assigns and no latch is inferred.
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push && !pop)      count_d = count_q + 9'd1;
        else if (pop && !push) count_d = count_q - 9'd1;
        if (bus.clear_overflow)              overflow_d = 1'b0;
        else if (push_req && full && !pop)   overflow_d = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= 9'd0;
            overflow_q <= 1'b0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // NOTE: storage is not reset; the empty flag masks stale words, so fifo_data still reads 0 after reset.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= entry;
    end

    assign bus.output_sample  = output_sample_q;
    assign bus.channel_select = channel_select_q;
    assign bus.fifo_data      = empty ? '0 : mem_q[rd_ptr_q];
    assign bus.fifo_empty     = empty;
    assign bus.fifo_full      = full;
    assign bus.fifo_count     = count_q;
    assign bus.overflow       = overflow_q;
    assign bus.bad_frame_cnt  = bad_frame_cnt_q;
endmodule

// File: tb/tb_sample_collector.sv
// Self-checking bench for sample_collector (4 channels, 4-deep FIFO): the bench plays the pin channels
// and the FIFO reader; a table of scans plus hand-written overflow/reset sequences feed a scoreboard queue.
module tb_sample_collector;
    localparam int NCH   = 4;
    localparam int DEPTH = 4;
`ifdef SAMPLE_TIMESTAMP_EN
    localparam int ENTRY_W = 72;
`else
    localparam int ENTRY_W = 40;
`endif

    typedef logic [ENTRY_W-1:0] entry_t;
    typedef struct {
        logic [31:0] data;
        logic [7:0]  ch;
        bit          push;
        bit          stop;
        bit          rd;
    } vec_t;

    logic   clk = 1'b0;
    logic   reset;
    int     n_cmp = 0;
    int     n_fail = 0;
    bit     first;
    entry_t exp_q[$];
    vec_t   vecs[12];

    sample_collector_if bus();

    sample_collector #(.NUM_CHANNELS(NCH), .FIFO_DEPTH(DEPTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk(input logic [15:0] cnt, input logic b);
        return {cnt, 15'h55E7, b};
    endfunction

    function automatic entry_t mk_entry(input logic [7:0] ch, input logic [31:0] data);
`ifdef SAMPLE_TIMESTAMP_EN
        return {bus.current_time, ch, data};
`else
        return {ch, data};
`endif
    endfunction

    task automatic settle();
        @(negedge clk);
        bus.fifo_rd        = 1'b0;
        bus.clear_overflow = 1'b0;
    endtask

    // Waits for one strobe, answers it as the addressed channel, and leaves control at the CAPT cycle.
    task automatic strobe(input logic [31:0] data, input logic [7:0] ch, input bit push, input bit is_first,
                          input bit stop, input bit rd, input bit clr, input bit rst);
        int waited = 0;
        bit seen   = 1'b0;
        for (int i = 0; i < 20; i++) begin
            settle();
            if (bus.output_sample) begin
                seen = 1'b1;
                break;
            end
            waited++;
        end
        check("strobe_seen", 72'(seen), 72'(1));
        if (!seen) return;
        if (!is_first) check("strobe_spacing", 72'(waited), 72'(0));
        check("channel_select", 72'(bus.channel_select), 72'(ch));
        bus.sample_data = data;
        if (push) exp_q.push_back(mk_entry(ch, data));
        if (stop) bus.enable = 1'b0;
        @(negedge clk);
        check("strobe_one_cycle", 72'(bus.output_sample), 72'(0));
        bus.fifo_rd        = rd;
        bus.clear_overflow = clr;
        if (rst) begin
            reset      = 1'b1;
            bus.enable = 1'b0;
        end
    endtask

    task automatic drain();
        entry_t exp;
        settle();
        check("fifo_count", 72'(bus.fifo_count), 72'(exp_q.size()));
        while (exp_q.size() > 0) begin
            exp = exp_q.pop_front();
            check("fifo_not_empty", 72'(bus.fifo_empty), 72'(0));
            check("fifo_data", 72'(bus.fifo_data), 72'(exp));
            bus.fifo_rd = 1'b1;
            settle();
        end
        check("fifo_empty_after_drain", 72'(bus.fifo_empty), 72'(1));
    endtask

    initial begin
        vecs[0]  = '{mk(16'd1, 1'b0),           8'd0, 1'b1, 1'b0, 1'b1};
        vecs[1]  = '{mk(16'd1, 1'b1),           8'd1, 1'b1, 1'b0, 1'b0};
        vecs[2]  = '{mk(16'd1, 1'b0),           8'd2, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{mk(16'd1, 1'b1),           8'd3, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{mk(16'd2, 1'b0),           8'd0, 1'b1, 1'b0, 1'b0};
        vecs[5]  = '{32'h0,                     8'd1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{mk(16'd1, 1'b0),           8'd2, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{mk(16'd5, 1'b1),           8'd3, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{mk(16'd2, 1'b1),           8'd0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{mk(16'd7, 1'b0),           8'd1, 1'b1, 1'b1, 1'b0};
        vecs[10] = '{{16'h9, 15'h55E6, 1'b1},   8'd2, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{mk(16'hFFFF, 1'b0),        8'd3, 1'b1, 1'b1, 1'b0};

        reset              = 1'b1;
        bus.enable         = 1'b0;
        bus.current_time   = 32'd0;
        bus.sample_data    = 32'd0;
        bus.fifo_rd        = 1'b0;
        bus.clear_overflow = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_output_sample", 72'(bus.output_sample), 72'(0));
        check("rst_channel_select", 72'(bus.channel_select), 72'(0));
        check("rst_fifo_empty", 72'(bus.fifo_empty), 72'(1));
        check("rst_fifo_full", 72'(bus.fifo_full), 72'(0));
        check("rst_fifo_count", 72'(bus.fifo_count), 72'(0));
        check("rst_overflow", 72'(bus.overflow), 72'(0));
        check("rst_bad_frame_cnt", 72'(bus.bad_frame_cnt), 72'(0));
        check("rst_fifo_data", 72'(bus.fifo_data), 72'(0));
        reset = 1'b0;

        // Scanning is held off while current_time is 0.
        bus.enable = 1'b1;
        begin
            int strobes = 0;
            repeat (6) begin
                @(negedge clk);
                if (bus.output_sample) strobes++;
            end
            check("holdoff_time_zero", 72'(strobes), 72'(0));
        end
        bus.current_time = 32'd5;

        first = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (first) bus.enable = 1'b1;
            strobe(vecs[i].data, vecs[i].ch, vecs[i].push, first, vecs[i].stop, vecs[i].rd, 1'b0, 1'b0);
            first = vecs[i].stop;
            if (vecs[i].stop) drain();
        end
        check("bad_frame_cnt", 72'(bus.bad_frame_cnt), 72'(2));

        // Fill to full, drop a fifth entry while clear_overflow is high, then a sixth with no clear.
        bus.enable = 1'b1;
        for (int i = 0; i < 5; i++)
            strobe(mk(16'(256 + i), 1'b0), 8'(i % NCH), i < 4, i == 0, i == 4, 1'b0, i == 4, 1'b0);
        settle();
        check("clear_beats_set", 72'(bus.overflow), 72'(0));
        check("full_flag", 72'(bus.fifo_full), 72'(1));
        check("full_count", 72'(bus.fifo_count), 72'(4));
        bus.enable = 1'b1;
        strobe(mk(16'h105, 1'b0), 8'd1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
        check("overflow_set", 72'(bus.overflow), 72'(1));
        check("drop_keeps_count", 72'(bus.fifo_count), 72'(4));
        bus.clear_overflow = 1'b1;
        settle();
        check("overflow_cleared", 72'(bus.overflow), 72'(0));

        // Push into a full FIFO while popping the head in the same cycle.
        check("head_before_pop", 72'(bus.fifo_data), 72'(exp_q[0]));
        exp_q.delete(0);
        bus.enable = 1'b1;
        strobe(mk(16'h106, 1'b0), 8'd2, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
        settle();
        check("push_pop_full_count", 72'(bus.fifo_count), 72'(4));
        check("push_pop_head", 72'(bus.fifo_data), 72'(exp_q[0]));
        drain();

        // Reset in the middle of a capture empties the FIFO and restarts at channel 0.
        bus.enable = 1'b1;
        strobe(mk(16'h200, 1'b0), 8'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe(mk(16'h201, 1'b0), 8'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe(mk(16'h300, 1'b0), 8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        settle();
        check("midrst_output_sample", 72'(bus.output_sample), 72'(0));
        check("midrst_channel_select", 72'(bus.channel_select), 72'(0));
        check("midrst_fifo_empty", 72'(bus.fifo_empty), 72'(1));
        check("midrst_fifo_count", 72'(bus.fifo_count), 72'(0));
        check("midrst_bad_frame_cnt", 72'(bus.bad_frame_cnt), 72'(0));
        reset = 1'b0;
        exp_q.delete();

        // last_cnt cleared by reset: a repeat of 0x201 pushes, a counter of 0 does not.
        bus.current_time = 32'd100;
        bus.enable       = 1'b1;
        strobe(mk(16'h201, 1'b1), 8'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        strobe({16'h0, 15'h55E7, 1'b1}, 8'd1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        settle();
`ifdef SAMPLE_TIMESTAMP_EN
        check("timestamp", 72'(bus.fifo_data[71:40]), 72'(100));
`endif
        drain();

        bus.fifo_rd = 1'b1;
        settle();
        check("pop_empty_ignored", 72'(bus.fifo_count), 72'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/sample_collector.md
SAMPLE_COLLECTOR -- requirements
Module: sample_collector

Interface
REQ-001 Parameter NUM_CHANNELS, default 8; number of pin channels scanned, channel_select values 0..NUM_CHANNELS-1, range 1..256.
REQ-002 Parameter FIFO_DEPTH, default 16; sample FIFO entries, power of two, 2..256.
REQ-003 clk  input  1  single clock, all logic on rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 enable  input  1  level; 1 = scan channels, 0 = stop after the current channel.
REQ-006 current_time  input  32  global time counter; scanning is held off while it is 0.
REQ-007 output_sample  output  1  sample request strobe to all pin channels.
REQ-008 channel_select  output  8  channel addressed by output_sample.
REQ-009 sample_data  input  32  shared sample bus, valid one cycle after output_sample; format {cnt[15:0], 15'h55E7, bit}.
REQ-010 fifo_rd  input  1  pop request from the downstream reader.
REQ-011 fifo_data  output  40 (72 with SAMPLE_TIMESTAMP_EN)  head entry {[timestamp,] channel[7:0], sample_data[31:0]}.
REQ-012 fifo_empty / fifo_full  output  1 each  FIFO status flags.
REQ-013 fifo_count  output  9  current occupancy, 0..FIFO_DEPTH.
REQ-014 overflow  output  1  sticky flag: an entry was dropped.
REQ-015 clear_overflow  input  1  clears overflow; takes priority over a simultaneous new set.
REQ-016 bad_frame_cnt  output  16  saturating count of captures with an invalid marker.

Function
REQ-017 FSM states are IDLE, REQ and CAPT; one channel takes exactly 2 cycles (REQ then CAPT).
- IDLE: no strobe; moves to REQ when enable=1 and current_time!=0.
REQ-018 In REQ, output_sample=1 and channel_select=ch for exactly one cycle; the next state is always CAPT.
REQ-019 In CAPT, output_sample=0 and sample_data is sampled; the frame is valid iff sample_data[15:1]==15'h55E7.
REQ-020 Invalid frame: no push; bad_frame_cnt increments and saturates at 16'hFFFF.
REQ-021 Valid frame: push {ch, sample_data} iff sample_data[31:16] != last_cnt[ch].
- last_cnt[ch] is updated to sample_data[31:16] on every valid frame, whether pushed or not.
REQ-022 ch sequence after CAPT:
- increments, wrapping from NUM_CHANNELS-1 to 0;
- goes to REQ if enable=1 and current_time!=0, else to IDLE;
- ch is retained across IDLE.
REQ-023 FIFO behaviour:
- first-word-fall-through; fifo_data is valid whenever fifo_empty=0;
- a pop takes effect at the clock edge of fifo_rd=1;
- pop while empty is ignored.
REQ-024 Push while full (and no pop that cycle): entry dropped, overflow set, FIFO contents unchanged.
REQ-025 Simultaneous push and pop: when full, both succeed and the count is unchanged; when empty, only the push takes effect.
REQ-026 Read and write pointers are log2(FIFO_DEPTH) bits and wrap naturally; fifo_count is tracked separately for the full/empty flags.
REQ-027 enable falling during REQ still completes CAPT for that channel; no partial capture is discarded.

Reset
REQ-028 On reset:
- state=IDLE, ch=0, output_sample=0, channel_select=0;
- FIFO emptied: fifo_empty=1, fifo_full=0, fifo_count=0;
- overflow=0, bad_frame_cnt=0, all last_cnt=0, fifo_data=0.
REQ-029 Reset asserted mid-scan aborts any capture in progress; no push occurs in the reset cycle.

Configuration
REQ-030 Macro SAMPLE_TIMESTAMP_EN:
- defined: each entry is prefixed with the current_time value latched in the CAPT cycle, and fifo_data is 72 bits;
- undefined: no timestamp storage, and fifo_data is 40 bits.

Verification
REQ-031 NUM_CHANNELS=4, enable=1, current_time=5, each channel returns cnt=1 -> strobes on ch 0,1,2,3 two cycles apart; four entries pushed in channel order.
REQ-032 Same cnt returned twice on ch2 -> only the first capture is pushed; the second scan of ch2 pushes nothing.
REQ-033 sample_data=32'hZ/0 on ch1 -> no push for ch1; bad_frame_cnt=1.
REQ-034 FIFO_DEPTH=4, no reads, five distinct samples -> fifo_full=1, count=4, overflow=1, 5th entry lost; clear_overflow -> overflow=0.
REQ-035 Full FIFO with fifo_rd=1 in the same cycle as a push -> count stays 4; the head advances to the 2nd entry.
REQ-036 reset asserted during CAPT -> next cycle output_sample=0, fifo_empty=1, ch=0; with SAMPLE_TIMESTAMP_EN, a capture at current_time=100 -> fifo_data[71:40]=100.
